matrix_scan_ctrl: RTL and testbench
===================================

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter ROWS, default 8: matrix row count, 2..16.
REQ-002 Parameter COLS, default 8: matrix column count per colour, 1..32.
REQ-003 Parameter DIV, default 5000: clock cycles each row is held (dwell); DIV > BLANK.
REQ-004 Parameter BLANK, default 8: anti-ghost blank cycles at the start of each dwell; 0 allowed.
REQ-005 Parameter ROW_ACTIVE_LOW, default 1: selected row driven 0 when 1, driven 1 when 0.
REQ-006 clk  in  1  single system clock; all logic is on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  write strobe for one row of the back buffer.
REQ-009 wr_row  in  clog2(ROWS)  target row index.
REQ-010 wr_r  in  COLS  red column bits; 1 means LED lit.
REQ-011 wr_g  in  COLS  green column bits; 1 means LED lit.
REQ-012 swap_req  in  1  request to present the back buffer; level or pulse.
REQ-013 swap_ack  out  1  one-cycle pulse on the cycle the buffers flip.
REQ-014 frame_start  out  1  one-cycle pulse on the first cycle of row 0 dwell.
REQ-015 output_row  out  ROWS  row select, one-hot in the active sense.
REQ-016 output_col_r  out  COLS  red column drive, active-high.
REQ-017 output_col_g  out  COLS  green column drive, active-high.

Function
REQ-018 The block SHALL hold two banks (front and back) of ROWS x 2 x COLS bits; only the front bank is displayed.
REQ-019 A write with wr_en=1 and wr_row<ROWS SHALL update that back-bank row at the next edge; writes with wr_row>=ROWS SHALL be ignored.
REQ-020 The FSM SHALL have states BLANK and SHOW. Per row, BLANK lasts BLANK cycles and SHOW lasts DIV-BLANK cycles; with BLANK=0, the FSM enters SHOW directly.
REQ-021 In BLANK, all rows SHALL be inactive and both column buses SHALL be 0.
REQ-022 In SHOW, only the current row SHALL be active and the columns SHALL equal the front-bank contents of that row.
REQ-023 After the last dwell cycle, the row pointer SHALL advance; ROWS-1 wraps to 0. The frame period SHALL be exactly ROWS*DIV cycles.
REQ-024 swap_req=1 on any cycle SHALL set a pending flag. The flip SHALL occur only on the last dwell cycle of row ROWS-1 with the flag set, and SHALL assert swap_ack on that cycle and clear the flag.
REQ-025 swap_req=1 while the flag is already set SHALL merge into a single swap.
REQ-026 swap_req=1 on the flip cycle itself SHALL leave the flag set for the next frame.
REQ-027 A write on the flip cycle SHALL land in the pre-flip back bank, and so SHALL be displayed in the new frame.
REQ-028 After a flip, the new back bank SHALL hold the previous front contents; no copy or clear is performed.
REQ-029 Outputs SHALL be registered, with a latency of 1 cycle from FSM state to pins.

Reset
REQ-030 rst SHALL clear both banks, the pending flag, the dwell counter and the row pointer, and SHALL place the FSM in BLANK.
REQ-031 During reset, and on the first cycle after it: all rows inactive, columns 0, swap_ack=0, frame_start=0.
REQ-032 The first frame_start after reset SHALL occur on the first cycle of row 0 dwell following release.
REQ-033 Reset asserted mid-frame or mid-write SHALL discard all state, with no partial swap.

Structure
REQ-034 Package matrix_pkg SHALL hold the FSM state enum, default parameter constants, and the active-level helper constant.
REQ-035 Bank storage and flip logic SHALL live in sub-module matrix_fb_bank; scan timing and output registering SHALL stay in matrix_scan_ctrl.

Verification (ROWS=4, COLS=4, DIV=10, BLANK=2)
REQ-036 Reset, idle for 100 cycles: output_row=4'b1111 and columns 0 throughout; frame_start period = 40 cycles.
REQ-037 Write row1 r=4'hA, g=4'h5, then pulse swap_req: swap_ack fires at the frame end. Next frame, row-1 SHOW shows output_row=4'b1101, col_r=A, col_g=5, and BLANK cycles show 0.
REQ-038 Write with wr_row=3 and no swap_req for 3 frames: the display stays unchanged and swap_ack never fires.
REQ-039 Three swap_req pulses within one frame: exactly one swap_ack. swap_req held on the flip cycle: a second swap_ack one frame later.
REQ-040 Write row0=4'hF on the flip cycle: row 0 shows col_r=F in the following frame.
REQ-041 Assert rst during row-2 SHOW with a swap pending: outputs inactive next cycle, no swap_ack, all rows blank after re-swap.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types, default parameters and row-level helper for the matrix scanner
// Contents:
//   scan_state_e   : per-row FSM state (blank window, then show window)
//   DEF_*          : default parameter values for the scanner and its bank
//   row_level()    : maps "row selected" onto the physical row pin level
package matrix_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam int DEF_ROWS           = 8;
  localparam int DEF_COLS           = 8;
  localparam int DEF_DIV            = 5000;
  localparam int DEF_BLANK          = 8;
  localparam int DEF_ROW_ACTIVE_LOW = 1;

  // Active-low boards invert the select, so a selected row reads 0 on the pin.
  function automatic logic row_level(input logic active_low, input logic selected);
    return selected ^ active_low;
  endfunction

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// rtl/matrix_scan_ctrl_if.sv - back-buffer write bus and swap handshake for the matrix scanner
// Signals:
//   wr_en, wr_row, wr_r, wr_g : one-row write into the back bank
//   swap_req                  : request to present the back bank (level or pulse)
//   swap_ack                  : one-cycle pulse when the banks flip
// Modports: master (host side), slave (scanner side)
interface matrix_scan_ctrl_if
  import matrix_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);
  localparam int RW = $clog2(ROWS);

  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_r;
  logic [COLS-1:0] wr_g;
  logic            swap_req;
  logic            swap_ack;

  modport master (output wr_en, wr_row, wr_r, wr_g, swap_req, input swap_ack);
  modport slave  (input wr_en, wr_row, wr_r, wr_g, swap_req, output swap_ack);

endinterface

// File: rtl/matrix_fb_bank.sv
// rtl/matrix_fb_bank.sv - double-buffered red/green row storage with bank flip
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears both banks)
//   wr_en_i, wr_row_i : back-bank row write strobe and row index
//   wr_r_i, wr_g_i    : row contents to write
//   flip_i            : exchange front and back banks at this edge
//   rd_row_i          : front-bank row to read
//   rd_r_o, rd_g_o    : front-bank contents of rd_row_i (combinational)
module matrix_fb_bank
  import matrix_pkg::*;
#(
  parameter int  ROWS = DEF_ROWS,
  parameter int  COLS = DEF_COLS,
  localparam int RW   = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en_i,
  input  logic [RW-1:0]   wr_row_i,
  input  logic [COLS-1:0] wr_r_i,
  input  logic [COLS-1:0] wr_g_i,
  input  logic            flip_i,
  input  logic [RW-1:0]   rd_row_i,
  output logic [COLS-1:0] rd_r_o,
  output logic [COLS-1:0] rd_g_o
);

  localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);

  logic [COLS-1:0] mem_r_q [2][ROWS];
  logic [COLS-1:0] mem_g_q [2][ROWS];
  logic            front_sel_q;
  logic            wr_ok;

  // Indices past the last row are dropped (only possible when ROWS is not a power of two).
  assign wr_ok = wr_en_i && ({1'b0, wr_row_i} < ROWS_L);

  // The write decode uses the pre-flip select, so a write on the flip edge lands in
  // the bank that becomes the front and is shown in the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_sel_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem_r_q[b][r] <= '0;
          mem_g_q[b][r] <= '0;
        end
      end
    end else begin
      if (flip_i) begin
        front_sel_q <= ~front_sel_q;
      end
      if (wr_ok) begin
        mem_r_q[~front_sel_q][wr_row_i] <= wr_r_i;
        mem_g_q[~front_sel_q][wr_row_i] <= wr_g_i;
      end
    end
  end

  assign rd_r_o = mem_r_q[front_sel_q][rd_row_i];
  assign rd_g_o = mem_g_q[front_sel_q][rd_row_i];

endmodule

// File: rtl/matrix_scan_ctrl.sv
// rtl/matrix_scan_ctrl.sv - row-multiplexed bi-colour LED matrix scanner with double buffering
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : back-bank write bus and swap_req/swap_ack handshake
//   frame_start       : pulse on the first cycle of row 0 dwell (registered)
//   output_row        : row select, one-hot in the active sense (registered)
//   output_col_r/_g   : red/green column drive, active-high (registered)
// All pins lag the FSM state by one cycle.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int DIV            = DEF_DIV,
  parameter int BLANK          = DEF_BLANK,
  parameter int ROW_ACTIVE_LOW = DEF_ROW_ACTIVE_LOW
) (
  input  logic                clk,
  input  logic                rst,
  matrix_scan_ctrl_if.slave   bus,
  output logic                frame_start,
  output logic [ROWS-1:0]     output_row,
  output logic [COLS-1:0]     output_col_r,
  output logic [COLS-1:0]     output_col_g
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0]   CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW_IDLE   = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          pending_q, pending_d;
  logic          last_dwell;
  logic          flip;

  logic [COLS-1:0] front_r, front_g;

  logic [ROWS-1:0] row_sel_d, row_sel_q;
  logic [COLS-1:0] col_r_d, col_r_q;
  logic [COLS-1:0] col_g_d, col_g_q;
  logic            frame_start_d, frame_start_q;
  logic            swap_ack_d, swap_ack_q;

  matrix_fb_bank #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (bus.wr_en),
    .wr_row_i (bus.wr_row),
    .wr_r_i   (bus.wr_r),
    .wr_g_i   (bus.wr_g),
    .flip_i   (flip),
    .rd_row_i (row_q),
    .rd_r_o   (front_r),
    .rd_g_o   (front_g)
  );

  // State register: FSM state, dwell counter, row pointer and swap-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      row_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic.
  always_comb begin
    last_dwell = (cnt_q == CNT_LAST);
    flip       = last_dwell && (row_q == ROW_LAST) && pending_q;

    cnt_d = last_dwell ? '0 : cnt_q + 1'b1;
    row_d = row_q;
    if (last_dwell) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end

    // A request on the flip cycle re-arms the flag, so it carries into the next frame.
    pending_d = bus.swap_req | (pending_q & ~flip);

    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if ((BLANK == 0) || (cnt_q == BLANK_LAST)) state_d = ST_SHOW;
      ST_SHOW:  if (last_dwell && (BLANK != 0))            state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Output decode. A row with no lit LED in either colour is left unselected, so an
  // empty frame keeps every row inactive.
  always_comb begin
    row_sel_d     = ROW_IDLE;
    col_r_d       = '0;
    col_g_d       = '0;
    frame_start_d = (cnt_q == '0) && (row_q == '0);
    swap_ack_d    = flip;
    if (state_q == ST_SHOW) begin
      col_r_d = front_r;
      col_g_d = front_g;
      for (int i = 0; i < ROWS; i++) begin
        row_sel_d[i] = row_level(ROW_ACTIVE_LOW != 0,
                                 (row_q == RW'(i)) && ((|front_r) || (|front_g)));
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_sel_q     <= ROW_IDLE;
      col_r_q       <= '0;
      col_g_q       <= '0;
      frame_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
    end else begin
      row_sel_q     <= row_sel_d;
      col_r_q       <= col_r_d;
      col_g_q       <= col_g_d;
      frame_start_q <= frame_start_d;
      swap_ack_q    <= swap_ack_d;
    end
  end

  assign output_row   = row_sel_q;
  assign output_col_r = col_r_q;
  assign output_col_g = col_g_q;
  assign frame_start  = frame_start_q;
  assign bus.swap_ack = swap_ack_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb/tb_matrix_scan_ctrl.sv - directed self-checking bench for matrix_scan_ctrl
module tb_matrix_scan_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DIV   = 10;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [3:0] output_row;
  logic [3:0] output_col_r;
  logic [3:0] output_col_g;

  matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  matrix_scan_ctrl #(
    .ROWS           (ROWS),
    .COLS           (COLS),
    .DIV            (DIV),
    .BLANK          (BLANK),
    .ROW_ACTIVE_LOW (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .frame_start  (frame_start),
    .output_row   (output_row),
    .output_col_r (output_col_r),
    .output_col_g (output_col_g)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         off;
    logic [3:0] row;
    logic [3:0] r;
    logic [3:0] g;
    logic       fs;
    logic       ack;
  } probe_t;

  probe_t tbl [11];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Packed as {2'b0, row, col_r, col_g, frame_start, swap_ack}.
  task automatic pins(input string name, input logic [3:0] row, input logic [3:0] r,
                      input logic [3:0] g, input logic fs, input logic ack);
    chk(name, {2'b0, output_row, output_col_r, output_col_g, frame_start, bus.swap_ack},
              {2'b0, row, r, g, fs, ack});
  endtask

  initial begin
    // Frame after the first swap; offset 0 is the swap_ack pin cycle (state 119).
    tbl[0]  = '{0,  4'b1111, 4'h0, 4'h0, 1'b0, 1'b1};
    tbl[1]  = '{1,  4'b1111, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[2]  = '{3,  4'b1111, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{11, 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{12, 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{13, 4'b1101, 4'hA, 4'h5, 1'b0, 1'b0};
    tbl[6]  = '{17, 4'b1101, 4'hA, 4'h5, 1'b0, 1'b0};
    tbl[7]  = '{20, 4'b1101, 4'hA, 4'h5, 1'b0, 1'b0};
    tbl[8]  = '{21, 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{40, 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[10] = '{41, 4'b1111, 4'h0, 4'h0, 1'b1, 1'b0};

    rst          = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_row   = '0;
    bus.wr_r     = '0;
    bus.wr_g     = '0;
    bus.swap_req = 1'b0;

    tick();
    tick();
    pins("in_reset", 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc = 0;
    pins("first_after_reset", 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0);

    // Idle: empty banks, frame_start every 40 cycles starting at pin cycle 1.
    for (int i = 0; i < 100; i++) begin
      tick();
      pins("idle", 4'b1111, 4'h0, 4'h0, (cyc % 40) == 1, 1'b0);
    end

    // Write row 1 then request a swap; the flip is at the end of state frame 80..119.
    bus.wr_en  = 1'b1;
    bus.wr_row = 2'd1;
    bus.wr_r   = 4'hA;
    bus.wr_g   = 4'h5;
    tick();
    bus.wr_en    = 1'b0;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    while (cyc < 120) begin
      tick();
      if (cyc < 120) chk("early_ack", {15'b0, bus.swap_ack}, 16'h0);
    end
    for (int i = 0; i < 11; i++) begin
      run_to(120 + tbl[i].off);
      pins("swap_frame", tbl[i].row, tbl[i].r, tbl[i].g, tbl[i].fs, tbl[i].ack);
    end

    // Back-bank write without a swap must not reach the display.
    bus.wr_en  = 1'b1;
    bus.wr_row = 2'd3;
    bus.wr_r   = 4'hF;
    bus.wr_g   = 4'hF;
    tick();
    bus.wr_en = 1'b0;
    while (cyc < 281) begin
      tick();
      chk("no_swap_ack", {15'b0, bus.swap_ack}, 16'h0);
      if (((cyc - 1) % 40) == 15) pins("hold_row1", 4'b1101, 4'hA, 4'h5, 1'b0, 1'b0);
      if (((cyc - 1) % 40) == 35) pins("hold_row3", 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0);
    end

    // Three requests merge into one flip; a request on the flip cycle re-arms for the next
    // frame; a row-0 write on that second flip cycle is shown in the frame that follows.
    while (cyc < 402) begin
      bus.swap_req = (cyc == 285) || (cyc == 290) || (cyc == 295) || (cyc == 319);
      bus.wr_en    = (cyc == 359);
      bus.wr_row   = 2'd0;
      bus.wr_r     = 4'hF;
      bus.wr_g     = 4'h0;
      tick();
      bus.swap_req = 1'b0;
      bus.wr_en    = 1'b0;
      chk("ack_pattern", {15'b0, bus.swap_ack}, {15'b0, (cyc == 320) || (cyc == 360)});
      if (cyc == 333) pins("f320_row1", 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0);
      if (cyc == 353) pins("f320_row3", 4'b0111, 4'hF, 4'hF, 1'b0, 1'b0);
      if (cyc == 363) pins("f360_row0", 4'b1110, 4'hF, 4'h0, 1'b0, 1'b0);
      if (cyc == 373) pins("f360_row1", 4'b1101, 4'hA, 4'h5, 1'b0, 1'b0);
      if (cyc == 393) pins("f360_row3", 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0);
    end

    // Swap pending, then reset during row-2 SHOW (state 425).
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    run_to(425);
    pins("pre_reset_row2", 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    pins("mid_frame_reset", 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 120) begin
      bus.swap_req = (cyc == 45);
      tick();
      bus.swap_req = 1'b0;
      pins("post_reset", 4'b1111, 4'h0, 4'h0, (cyc % 40) == 1, cyc == 80);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
